instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Encoder side of the opcode/control decode path. Accepts instruction fields (class, regs, funct, imm, target) on a
//  valid/ready handshake and packs them into 32-bit MIPS words. Writes each word to instruction memory at an
//  auto-incrementing byte address, so benches and boot logic can load programs that control_unit then decodes.
// PARAMETERS
//  ADDR_W     32   width of instruction-memory byte address
//  MAX_WORDS  256  words written per program load; FULL is entered after this many
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous reset, active low
//  start      in   1       1-cycle pulse: load base_addr, clear count/err, enter RUN
//  base_addr  in   ADDR_W  first write address (word aligned; bits[1:0] are ignored and forced to 0)
//  in_valid   in   1       instruction fields valid
//  in_ready   out  1       encoder can accept fields this cycle
//  in_op      in   3       0=R-type 1=lw 2=sw 3=beq 4=bne 5=j 6,7=illegal
//  in_rs      in   5       rs field
//  in_rt      in   5       rt field
//  in_rd      in   5       rd field (R-type only)
//  in_funct   in   6       funct field (R-type only)
//  in_imm     in   16      immediate/offset (lw, sw, beq, bne)
//  in_target  in   26      jump target (j)
//  mem_valid  out  1       mem_addr/mem_wdata hold a word to write
//  mem_ready  in   1       memory accepts the word this cycle
//  mem_addr   out  ADDR_W  byte address of the word
//  mem_wdata  out  32      encoded instruction
//  count      out  16      words written since start
//  busy       out  1       state==RUN or mem_valid
//  full       out  1       state==FULL
//  err        out  1       sticky: an illegal in_op was accepted
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, count=0, err=0, in_ready=0.
//  FSM: IDLE --start--> RUN; RUN --(MAX_WORDS-th word handed off)--> FULL; FULL --start--> RUN; any --start--> RUN.
//  in_ready = (state==RUN) && (!mem_valid || mem_ready) && !(count+mem_valid == MAX_WORDS).
//  Fields are accepted when in_valid && in_ready. On the next edge, mem_wdata gets the encoded word and mem_valid=1.
//  Latency: 1 cycle from acceptance to mem_valid. Throughput: 1 word/cycle when mem_ready is held at 1.
//  Encodings ({} is MSB first):
//   R-type {6'b000000, rs, rt, rd, 5'b00000, funct}
//   lw {6'b100011, rs, rt, imm}     sw {6'b101011, rs, rt, imm}
//   beq {6'b000100, rs, rt, imm}    bne {6'b000101, rs, rt, imm}    j {6'b000010, target}
//  Unused fields are ignored.
//  Illegal op (6,7): accepted (handshake completes), nothing is written, count and address are unchanged, err<=1.
//  Handoff happens when mem_valid && mem_ready. On handoff: count+=1 and mem_addr+=4, wrapping modulo 2^ADDR_W.
//   mem_valid drops unless a new word is accepted in the same cycle.
//  While mem_valid=1 && mem_ready=0: mem_addr and mem_wdata are held stable, and in_ready=0.
//  After the MAX_WORDS-th handoff: state=FULL and in_ready=0. Further in_valid is not accepted (no loss, no error).
//  start while mem_valid=1: the pending word is discarded (mem_valid<=0), mem_addr<=base_addr, count<=0, err<=0.
//   start takes priority over a handoff or acceptance in the same cycle; in_ready=0 during the start cycle.
//  start while in IDLE/FULL/RUN: always restarts as above. Async reset mid-transfer drops everything immediately.
// TESTING
//  1 Reset: rst_n=0 with mem_valid=1 -> all outputs 0 immediately (async); after release state=IDLE, in_ready=0.
//  2 start base=0x0040, op=0 rs=1 rt=2 rd=3 funct=0x20, mem_ready=1 -> 1 cycle later
//    addr=0x0040, wdata=0x00221820, count=1.
//  3 Back-to-back lw rs=29 rt=8 imm=0x0004, then sw same fields, then j target=0x0000010
//    -> 0x8FA80004 @0x40, 0xAFA80004 @0x44, 0x08000010 @0x48 on consecutive cycles.
//  4 Backpressure: mem_ready=0 for 3 cycles with beq rs=4 rt=5 imm=0xFFFE pending
//    -> wdata 0x1085FFFE and addr stable, in_ready=0; bne follows after handoff.
//  5 Illegal op=7 mid-stream -> err=1, count/addr unchanged, next legal op written at next address; start clears err.
//  6 MAX_WORDS=4: send 6 instructions -> 4 writes, full=1, in_ready=0; start base=0xFFFFFFFC
//    -> 2nd word at addr 0x0 (wrap), count restarts at 0.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words and streams them to instruction memory
// at an auto-incrementing byte address, stopping after MAX_WORDS handoffs.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       count,
    output logic              busy,
    output logic              full,
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StRun, StFull} state_e;

    localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

    state_e            r_state;
    state_e            w_state_next;
    logic              r_mem_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [15:0]       r_count;
    logic              r_err;

    logic              w_in_ready;
    logic              w_handoff;
    logic              w_accept;
    logic              w_legal;
    logic [31:0]       w_word;
    logic [16:0]       w_inflight;
    logic              w_last_handoff;

    // Words already written plus the one waiting; no acceptance once that reaches the limit.
    assign w_inflight     = {1'b0, r_count} + {16'b0, r_mem_valid};
    assign w_handoff      = r_mem_valid && mem_ready && !start;
    assign w_accept       = in_valid && w_in_ready;
    assign w_legal        = (in_op <= 3'd5);
    assign w_last_handoff = w_handoff && (({1'b0, r_count} + 17'd1) == MaxWords);

    always_comb begin
        w_word = 32'h0;
        case (in_op)
            3'd0:    w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, in_funct};
            3'd1:    w_word = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    w_word = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    w_word = {6'b000100, in_rs, in_rt, in_imm};
            3'd4:    w_word = {6'b000101, in_rs, in_rt, in_imm};
            3'd5:    w_word = {6'b000010, in_target};
            default: w_word = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (start) begin
            w_state_next = StRun;
        end else if (r_state == StRun && w_last_handoff) begin
            w_state_next = StFull;
        end
    end

    always_comb begin
        w_in_ready = (r_state == StRun) && (!r_mem_valid || mem_ready) &&
                     (w_inflight != MaxWords) && !start;
        in_ready   = w_in_ready;
        busy       = (r_state == StRun) || r_mem_valid;
        full       = (r_state == StFull);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_count     <= 16'h0;
            r_err       <= 1'b0;
        end else if (start) begin
            // Restart discards any pending word.
            r_mem_valid <= 1'b0;
            r_mem_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
            r_count     <= 16'h0;
            r_err       <= 1'b0;
        end else begin
            if (w_handoff) begin
                r_mem_addr <= r_mem_addr + ADDR_W'(4);
                r_count    <= r_count + 16'd1;
            end
            if (w_accept && w_legal) begin
                r_mem_valid <= 1'b1;
                r_mem_wdata <= w_word;
            end else if (w_handoff) begin
                r_mem_valid <= 1'b0;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign count     = r_count;
    assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with a write scoreboard; MAX_WORDS is 4 so the
// FULL limit is reachable quickly.
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [4:0]  in_rs = 5'd0;
    logic [4:0]  in_rt = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [5:0]  in_funct = 6'd0;
    logic [15:0] in_imm = 16'h0;
    logic [25:0] in_target = 26'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] count;
    logic        busy;
    logic        full;
    logic        err;

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    logic [31:0] exp_addr = 32'h0;
    wr_t         sb[$];
    int          hcyc[$];
    vec_t        tbl[7];

    instr_encoder #(
        .ADDR_W   (32),
        .MAX_WORDS(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rs    (in_rs),
        .in_rt    (in_rt),
        .in_rd    (in_rd),
        .in_funct (in_funct),
        .in_imm   (in_imm),
        .in_target(in_target),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .count    (count),
        .busy     (busy),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Write monitor: every handoff must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && !start && mem_valid && mem_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL wr_unexpected: got write %h @%h, want none", mem_wdata, mem_addr);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 64'(mem_addr), 64'(e.addr));
                check("wr_data", 64'(mem_wdata), 64'(e.data));
                hcyc.push_back(cyc);
            end
        end
    end

    task automatic drive(input vec_t v);
        in_valid  = 1'b1;
        in_op     = v.op;
        in_rs     = v.rs;
        in_rt     = v.rt;
        in_rd     = v.rd;
        in_funct  = v.funct;
        in_imm    = v.imm;
        in_target = v.target;
    endtask

    task automatic send(input vec_t v);
        int n = 0;
        drive(v);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles, want 1");
        end else if (v.op <= 3'd5) begin
            sb.push_back('{addr: exp_addr, data: v.word});
            exp_addr += 32'd4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        @(posedge clk);
        #1;
        start    = 1'b0;
        sb.delete();
        hcyc.delete();
        exp_addr = base & ~32'd3;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{op: 3'd0, rs: 5'd1,  rt: 5'd2, rd: 5'd3,  funct: 6'h20, imm: 16'hFFFF,
                   target: 26'h0,       word: 32'h00221820};
        tbl[1] = '{op: 3'd1, rs: 5'd29, rt: 5'd8, rd: 5'd31, funct: 6'h3F, imm: 16'h0004,
                   target: 26'h3FFFFFF, word: 32'h8FA80004};
        tbl[2] = '{op: 3'd2, rs: 5'd29, rt: 5'd8, rd: 5'd0,  funct: 6'h00, imm: 16'h0004,
                   target: 26'h0,       word: 32'hAFA80004};
        tbl[3] = '{op: 3'd5, rs: 5'd7,  rt: 5'd9, rd: 5'd1,  funct: 6'h11, imm: 16'h1234,
                   target: 26'h0000010, word: 32'h08000010};
        tbl[4] = '{op: 3'd3, rs: 5'd4,  rt: 5'd5, rd: 5'd0,  funct: 6'h00, imm: 16'hFFFE,
                   target: 26'h0,       word: 32'h1085FFFE};
        tbl[5] = '{op: 3'd4, rs: 5'd4,  rt: 5'd5, rd: 5'd0,  funct: 6'h00, imm: 16'h0003,
                   target: 26'h0,       word: 32'h14850003};
        tbl[6] = '{op: 3'd7, rs: 5'd1,  rt: 5'd1, rd: 5'd1,  funct: 6'h01, imm: 16'h0001,
                   target: 26'h1,       word: 32'h0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_outputs", {mem_addr, mem_wdata}, 64'd0);

        // Async reset while a word is pending
        do_start(32'h40);
        mem_ready = 1'b0;
        send(tbl[0]);
        in_valid = 1'b0;
        check("pend_valid", 64'(mem_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("arst_valid", 64'(mem_valid), 64'd0);
        check("arst_addr_data", {mem_addr, mem_wdata}, 64'd0);
        check("arst_flags", {count, busy, full, err, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_idle_ready", 64'(in_ready), 64'd0);

        // Single R-type, 1-cycle latency
        mem_ready = 1'b1;
        do_start(32'h40);
        send(tbl[0]);
        in_valid = 1'b0;
        check("t2_lat_valid", 64'(mem_valid), 64'd1);
        check("t2_lat_word", {mem_addr, mem_wdata}, {32'h40, 32'h00221820});
        drain();
        check("t2_count", 64'(count), 64'd1);
        check("t2_busy", 64'(busy), 64'd1);

        // Back-to-back lw, sw, j
        do_start(32'h40);
        for (int i = 1; i <= 3; i++) send(tbl[i]);
        in_valid = 1'b0;
        drain();
        check("t3_count", 64'(count), 64'd3);
        check("t3_nhandoff", 64'(hcyc.size()), 64'd3);
        if (hcyc.size() == 3) begin
            check("t3_gap01", 64'(hcyc[1] - hcyc[0]), 64'd1);
            check("t3_gap12", 64'(hcyc[2] - hcyc[1]), 64'd1);
        end

        // Backpressure
        do_start(32'h100);
        mem_ready = 1'b0;
        send(tbl[4]);
        drive(tbl[5]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_in_ready", 64'(in_ready), 64'd0);
            check("t4_hold", {mem_addr, mem_wdata}, {32'h100, 32'h1085FFFE});
        end
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        send(tbl[5]);
        in_valid = 1'b0;
        drain();
        check("t4_count", 64'(count), 64'd2);

        // Illegal op mid-stream; unaligned base is forced to word alignment
        do_start(32'h203);
        send(tbl[0]);
        in_valid = 1'b0;
        drain();
        send(tbl[6]);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t5_err", 64'(err), 64'd1);
        check("t5_hold", {16'h0, count, mem_addr}, {16'h0, 16'd1, 32'h204});
        check("t5_no_write", 64'(mem_valid), 64'd0);
        send(tbl[2]);
        in_valid = 1'b0;
        drain();
        check("t5_count", 64'(count), 64'd2);
        check("t5_err_sticky", 64'(err), 64'd1);
        do_start(32'h300);
        check("t5_start_clr", {count, err}, 64'd0);

        // Fill to MAX_WORDS=4, extra instructions must be held off
        do_start(32'h400);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                send(tbl[i]);
            end else begin
                logic seen;
                seen = 1'b0;
                drive(tbl[i]);
                repeat (4) begin
                    @(negedge clk);
                    if (in_ready) seen = 1'b1;
                end
                check("t6_no_accept", 64'(seen), 64'd0);
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        drain();
        check("t6_full", 64'(full), 64'd1);
        check("t6_count", 64'(count), 64'd4);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_in_ready", 64'(in_ready), 64'd0);
        check("t6_err", 64'(err), 64'd0);
        do_start(32'hFFFF_FFFC);
        check("t6_restart", {count, full}, 64'd0);
        send(tbl[1]);
        send(tbl[2]);
        in_valid = 1'b0;
        drain();
        check("t6_wrap_count", 64'(count), 64'd2);
        check("t6_wrap_addr", 64'(mem_addr), 64'h4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
